// File: rtl/ir_assembler.sv
// Assembles BEATS bus beats into one instruction and queues it in a DEPTH-entry FIFO.
// Latency: instr_valid rises the cycle after the last beat is accepted.
// Backpressure: beat_ready drops only when the next beat would complete an instruction into a full FIFO.
module ir_assembler #(
    parameter  int DATA_W    = 8,
    parameter  int BEATS     = 2,
    parameter  int DEPTH     = 2,
    parameter  int LSB_FIRST = 1,
    localparam int INSTR_W   = DATA_W * BEATS,
    localparam int CNT_W     = $clog2(BEATS),
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [DATA_W-1:0]  data,
    output logic               beat_ready,
    input  logic               flush,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [INSTR_W-4:0] ir_addr,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [INSTR_W-1:0] partial_q, partial_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [LVL_W-1:0]   level_q, level_d;

    logic               last_beat;
    logic               beat_acc;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   slot;
    logic [INSTR_W-1:0] merged;

    always_comb begin
        last_beat  = (beat_cnt_q == LAST_BEAT);
        beat_ready = !last_beat || (level_q < FULL_LVL);
        beat_acc   = ena && beat_ready;
        push       = beat_acc && last_beat;
        pop        = (level_q != '0) && instr_ready;

        // Beat position inside the instruction depends on the configured order.
        slot   = (LSB_FIRST != 0) ? beat_cnt_q : (LAST_BEAT - beat_cnt_q);
        merged = partial_q;
        for (int s = 0; s < BEATS; s++) begin
            if (CNT_W'(s) == slot) begin
                merged[s*DATA_W +: DATA_W] = data;
            end
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        partial_d  = partial_q;
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q;

        if (flush) begin
            // Flush wins over any beat or pop presented in the same cycle.
            beat_cnt_d = '0;
            partial_d  = '0;
            head_d     = '0;
            tail_d     = '0;
            level_d    = '0;
        end else begin
            if (beat_acc) begin
                if (last_beat) begin
                    mem_d[tail_q] = merged;
                    tail_d        = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
                    beat_cnt_d    = '0;
                    partial_d     = '0;
                end else begin
                    partial_d  = merged;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            partial_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            partial_q  <= partial_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        instr_valid = (level_q != '0);
        instr       = instr_valid ? mem_q[head_q] : '0;
        opcode      = instr[INSTR_W-1 -: 3];
        ir_addr     = instr[INSTR_W-4:0];
        beat_cnt    = beat_cnt_q;
        level       = level_q;
    end

endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: two 2-beat instances (both beat orders) and one 4-beat, 3-deep instance.
module tb_ir_assembler;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Shared stimulus for the two 8x2 instances.
    logic        ena, flush, rdy;
    logic [7:0]  data;

    logic        beat_ready0, instr_valid0;
    logic [15:0] instr0;
    logic [2:0]  opcode0;
    logic [12:0] ir_addr0;
    logic [0:0]  beat_cnt0;
    logic [1:0]  level0;

    logic        beat_ready1, instr_valid1;
    logic [15:0] instr1;
    logic [2:0]  opcode1;
    logic [12:0] ir_addr1;
    logic [0:0]  beat_cnt1;
    logic [1:0]  level1;

    logic        ena2, flush2, rdy2;
    logic [7:0]  data2;
    logic        beat_ready2, instr_valid2;
    logic [31:0] instr2;
    logic [2:0]  opcode2;
    logic [28:0] ir_addr2;
    logic [1:0]  beat_cnt2;
    logic [1:0]  level2;

    int compared   = 0;
    int mismatched = 0;

    ir_assembler #(.DATA_W(8), .BEATS(2), .DEPTH(2), .LSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .data(data), .beat_ready(beat_ready0),
        .flush(flush), .instr_valid(instr_valid0), .instr_ready(rdy), .instr(instr0),
        .opcode(opcode0), .ir_addr(ir_addr0), .beat_cnt(beat_cnt0), .level(level0)
    );

    ir_assembler #(.DATA_W(8), .BEATS(2), .DEPTH(2), .LSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .data(data), .beat_ready(beat_ready1),
        .flush(flush), .instr_valid(instr_valid1), .instr_ready(rdy), .instr(instr1),
        .opcode(opcode1), .ir_addr(ir_addr1), .beat_cnt(beat_cnt1), .level(level1)
    );

    ir_assembler #(.DATA_W(8), .BEATS(4), .DEPTH(3), .LSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .ena(ena2), .data(data2), .beat_ready(beat_ready2),
        .flush(flush2), .instr_valid(instr_valid2), .instr_ready(rdy2), .instr(instr2),
        .opcode(opcode2), .ir_addr(ir_addr2), .beat_cnt(beat_cnt2), .level(level2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_w [3];
        int sent;
        int got;
        logic accepted;
        logic popped;
        exp_w[0] = 32'h04030201;
        exp_w[1] = 32'h08070605;
        exp_w[2] = 32'h0C0B0A09;

        rst = 1'b0; ena = 1'b0; flush = 1'b0; rdy = 1'b0; data = 8'h00;
        ena2 = 1'b0; flush2 = 1'b0; rdy2 = 1'b0; data2 = 8'h00;
        #3;
        chk("rst_valid",      32'(instr_valid0), 32'h0);
        chk("rst_instr",      32'(instr0),       32'h0);
        chk("rst_beat_cnt",   32'(beat_cnt0),    32'h0);
        chk("rst_level",      32'(level0),       32'h0);
        chk("rst_beat_ready", 32'(beat_ready0),  32'h1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Basic assembly, both beat orders.
        ena = 1'b1; data = 8'h34; rdy = 1'b1;
        tick();
        chk("basic_cnt1",  32'(beat_cnt0),    32'h1);
        chk("basic_nval",  32'(instr_valid0), 32'h0);
        data = 8'h12;
        tick();
        chk("basic_valid",  32'(instr_valid0), 32'h1);
        chk("basic_instr",  32'(instr0),       32'h1234);
        chk("basic_opcode", 32'(opcode0),      32'h0);
        chk("basic_addr",   32'(ir_addr0),     32'h1234);
        chk("msb_instr",    32'(instr1),       32'h3412);
        chk("msb_opcode",   32'(opcode1),      32'h1);
        ena = 1'b0;
        tick();
        chk("basic_one_cycle", 32'(instr_valid0), 32'h0);
        chk("basic_cleared",   32'(instr0),       32'h0);
        chk("msb_one_cycle",   32'(instr_valid1), 32'h0);

        // Back-pressure with the consumer stalled.
        rdy = 1'b0; ena = 1'b1;
        data = 8'hA1; tick();
        data = 8'hA2; tick();
        data = 8'hA3; tick();
        data = 8'hA4; tick();
        chk("bp_level2",  32'(level0),      32'h2);
        data = 8'hA5; tick();
        chk("bp_cnt1",    32'(beat_cnt0),   32'h1);
        chk("bp_stall",   32'(beat_ready0), 32'h0);
        data = 8'hA6; tick();
        chk("bp_ignored_cnt", 32'(beat_cnt0), 32'h1);
        chk("bp_ignored_lvl", 32'(level0),    32'h2);
        chk("bp_head0",       32'(instr0),    32'hA2A1);
        ena = 1'b0; rdy = 1'b1;
        tick();
        chk("bp_pop_level", 32'(level0),      32'h1);
        chk("bp_ready_back", 32'(beat_ready0), 32'h1);
        chk("bp_head1",     32'(instr0),      32'hA4A3);

        // Full FIFO with a simultaneous pop.
        rdy = 1'b0; ena = 1'b1; data = 8'hA6;
        tick();
        chk("full_level2", 32'(level0), 32'h2);
        data = 8'hB1; tick();
        chk("full_cnt1",  32'(beat_cnt0),   32'h1);
        chk("full_stall", 32'(beat_ready0), 32'h0);
        data = 8'hB2; rdy = 1'b1;
        tick();
        chk("full_refused_lvl", 32'(level0),    32'h1);
        chk("full_refused_cnt", 32'(beat_cnt0), 32'h1);
        chk("full_head",        32'(instr0),    32'hA6A5);
        tick();
        chk("pushpop_level", 32'(level0),    32'h1);
        chk("pushpop_cnt",   32'(beat_cnt0), 32'h0);
        chk("pushpop_head",  32'(instr0),    32'hB2B1);
        ena = 1'b0; rdy = 1'b0;

        // Flush with a beat in the same cycle.
        ena = 1'b1; data = 8'hC1;
        tick();
        chk("fl_cnt1", 32'(beat_cnt0), 32'h1);
        data = 8'hC2; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_level", 32'(level0),       32'h0);
        chk("fl_cnt",   32'(beat_cnt0),    32'h0);
        chk("fl_instr", 32'(instr0),       32'h0);
        chk("fl_valid", 32'(instr_valid0), 32'h0);
        data = 8'hD1; tick();
        data = 8'hD2; tick();
        ena = 1'b0;
        chk("fl_after_level", 32'(level0), 32'h1);
        chk("fl_after_instr", 32'(instr0), 32'hD2D1);
        rdy = 1'b1;
        tick();
        chk("fl_drain", 32'(level0), 32'h0);
        rdy = 1'b0;

        // Wide config with a random consumer.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && got < 3; cyc++) begin
            ena2  = (sent < 12);
            data2 = 8'(sent + 1);
            rdy2  = 1'($urandom_range(0, 1));
            accepted = ena2 && beat_ready2;
            popped   = instr_valid2 && rdy2;
            if (popped) begin
                chk($sformatf("wide_instr%0d", got), instr2, exp_w[got]);
                got++;
            end
            tick();
            if (accepted) sent++;
        end
        chk("wide_count", 32'(got), 32'h3);
        chk("wide_sent",  32'(sent), 32'd12);
        ena2 = 1'b0; rdy2 = 1'b0;

        // Reset mid-instruction on the wide instance.
        ena2 = 1'b1; data2 = 8'h11; tick();
        data2 = 8'h22; tick();
        ena2 = 1'b0;
        chk("wide_partial_cnt", 32'(beat_cnt2), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("wrst_valid",  32'(instr_valid2), 32'h0);
        chk("wrst_instr",  32'(instr2),       32'h0);
        chk("wrst_opcode", 32'(opcode2),      32'h0);
        chk("wrst_addr",   32'(ir_addr2),     32'h0);
        chk("wrst_cnt",    32'(beat_cnt2),    32'h0);
        chk("wrst_level",  32'(level2),       32'h0);
        chk("wrst_bready", 32'(beat_ready2),  32'h1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("wrst_post_cnt",   32'(beat_cnt2),    32'h0);
        chk("wrst_post_valid", 32'(instr_valid2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
